// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    // Level must count 0..DEPTH inclusive, hence one bit wider than the pointers.
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage with a registered, enabled read port and no reset,
// so it maps onto block RAM.
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level tracking, threshold flags, overflow/underflow
// pulses and a standard or first-word-fall-through read side.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH    = 32,
    parameter int         ADDR_WIDTH    = 10,
    parameter fifo_mode_e MODE          = FIFO_STD,
    parameter int         AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
    parameter int         AEMPTY_THRESH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    output logic                                full,
    output logic                                almost_full,
    output logic                                overflow,
    input  logic                                rd_en,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic                                rd_valid,
    output logic                                empty,
    output logic                                almost_empty,
    output logic                                underflow,
    output logic [level_width(ADDR_WIDTH)-1:0]  level
);

    localparam int            LW      = level_width(ADDR_WIDTH);
    localparam bit            FWFT    = (MODE == FIFO_FWFT);
    localparam bit            AE_EN   = (AEMPTY_THRESH >= 0);
    localparam logic [LW-1:0] DEPTH_L = LW'(2**ADDR_WIDTH);
    localparam logic [LW-1:0] AF_L    = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] AE_L    = AE_EN ? LW'(AEMPTY_THRESH) : '0;

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0]         level_q, level_nxt, pend_q, pend_nxt;
    logic [DATA_WIDTH-1:0] mem_q, out_q;
    logic wr_acc, rd_acc, pop, mv1, fetch, mem_rd;
    logic v1_q, v2_q, std_vld_q, has_q;
    logic full_q, af_q, ae_q, zero_q, ovf_q, udf_q, empty_o;

    // In FWFT the RAM output register is stage 1 and out_q is stage 2; pend_q
    // counts words written but not yet fetched, so prefetch never reads an
    // address being written on the same edge.
    always_comb begin
        empty_o   = FWFT ? !v2_q : zero_q;
        wr_acc    = wr_en && !full_q;
        pop       = rd_en && v2_q;
        mv1       = v1_q && (!v2_q || pop);
        fetch     = FWFT && (pend_q != '0) && (!v1_q || mv1);
        rd_acc    = FWFT ? pop : (rd_en && !zero_q);
        mem_rd    = FWFT ? fetch : rd_acc;
        level_nxt = level_q + LW'(wr_acc) - LW'(rd_acc);
        pend_nxt  = pend_q + LW'(wr_acc) - LW'(fetch);
    end

    fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (mem_rd),
        .rd_addr (rd_ptr),
        .rd_data (mem_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            pend_q    <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= AE_EN;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            std_vld_q <= 1'b0;
            has_q     <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            out_q     <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (mem_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            level_q   <= level_nxt;
            pend_q    <= pend_nxt;
            full_q    <= (level_nxt == DEPTH_L);
            af_q      <= (level_nxt >= AF_L);
            ae_q      <= AE_EN && (level_nxt <= AE_L);
            zero_q    <= (level_nxt == '0);
            ovf_q     <= wr_en && full_q;
            udf_q     <= rd_en && empty_o;
            std_vld_q <= !FWFT && rd_acc;
            // The RAM register is unreset; hide it until a real read lands.
            if (!FWFT && rd_acc) has_q <= 1'b1;
            if (fetch)    v1_q <= 1'b1;
            else if (mv1) v1_q <= 1'b0;
            if (mv1) begin
                out_q <= mem_q;
                v2_q  <= 1'b1;
            end else if (pop) begin
                v2_q  <= 1'b0;
            end
        end
    end

    assign full         = full_q;
    assign almost_full  = af_q;
    assign overflow     = ovf_q;
    assign almost_empty = ae_q;
    assign underflow    = udf_q;
    assign empty        = empty_o;
    assign level        = level_q;
    assign rd_valid     = FWFT ? v2_q : std_vld_q;
    assign rd_data      = FWFT ? out_q : (has_q ? mem_q : '0);

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one STD and one FWFT instance (16 x 8 bit), a shared
// vector table, a data scoreboard and hand-written latency/reset sequences.
module tb_sync_fifo;
    import fifo_pkg::*;

    typedef struct packed {
        logic       full, af, ovf, empty, ae, udf, rvld;
        logic [7:0] data;
        logic [4:0] lvl;
    } obs_t;

    typedef struct {
        bit          w, r;
        logic [7:0]  d;
        logic [10:0] exp;   // {lvl, full, af, empty, ae, ovf, udf}
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = '0;
    bit   m = 1'b0;         // 0: drive/observe STD instance, 1: FWFT instance

    logic full_s, af_s, ovf_s, empty_s, ae_s, udf_s, rvld_s;
    logic full_f, af_f, ovf_f, empty_f, ae_f, udf_f, rvld_f;
    logic [7:0] data_s, data_f;
    logic [4:0] lvl_s, lvl_f;
    obs_t obs_s, obs_f, o;

    int n_tests = 0, n_fail = 0, mlvl = 0;
    logic [7:0] sb[$];
    vec_t tbl[35];

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MODE(FIFO_STD),
                .AFULL_THRESH(12), .AEMPTY_THRESH(3)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en && !m), .wr_data(wr_data),
        .full(full_s), .almost_full(af_s), .overflow(ovf_s),
        .rd_en(rd_en && !m), .rd_data(data_s), .rd_valid(rvld_s),
        .empty(empty_s), .almost_empty(ae_s), .underflow(udf_s), .level(lvl_s));

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MODE(FIFO_FWFT),
                .AFULL_THRESH(12), .AEMPTY_THRESH(3)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en && m), .wr_data(wr_data),
        .full(full_f), .almost_full(af_f), .overflow(ovf_f),
        .rd_en(rd_en && m), .rd_data(data_f), .rd_valid(rvld_f),
        .empty(empty_f), .almost_empty(ae_f), .underflow(udf_f), .level(lvl_f));

    assign obs_s = {full_s, af_s, ovf_s, empty_s, ae_s, udf_s, rvld_s, data_s, lvl_s};
    assign obs_f = {full_f, af_f, ovf_f, empty_f, ae_f, udf_f, rvld_f, data_f, lvl_f};
    assign o     = m ? obs_f : obs_s;

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (mode %0d, t=%0t)", nm, act, exp, m, $time);
        end
    endfunction

    function automatic logic [10:0] mk(int lvl, bit emp, bit ovf, bit udf);
        return {5'(lvl), lvl == 16, lvl >= 12, emp, lvl <= 3, ovf, udf};
    endfunction

    function automatic logic [10:0] st();
        return {o.lvl, o.full, o.af, o.empty, o.ae, o.ovf, o.udf};
    endfunction

    // STD: every rd_valid cycle delivers one word. FWFT: a word leaves on pop.
    always @(negedge clk) begin
        if (rst_n && (m ? (rd_en && o.rvld) : o.rvld)) begin
            if (sb.size() == 0) chk("sb_underrun", 1, 0);
            else chk("rd_data", o.data, sb.pop_front());
        end
    end

    task automatic step(input bit w, input bit r, input logic [7:0] d);
        bit wa, ra;
        wr_en = w; rd_en = r; wr_data = d;
        wa = w && (mlvl < 16);
        ra = r && (m ? o.rvld : (mlvl > 0));
        if (wa) sb.push_back(d);
        mlvl = mlvl + int'(wa) - int'(ra);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        obs_t rv;
        rv = '0; rv.empty = 1'b1; rv.ae = 1'b1;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        sb.delete(); mlvl = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_std", obs_s, rv);
        chk("rst_fwft", obs_f, rv);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic flush();
        for (int n = 0; n < 50 && (o.lvl != 0 || o.rvld); n++)
            step(1'b0, m ? o.rvld : !o.empty, 8'h00);
        repeat (2) step(1'b0, 1'b0, 8'h00);
        chk("flush_lvl", o.lvl, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        obs_t rv;
        for (int md = 0; md < 2; md++) begin
            m = bit'(md);
            do_reset();
            // Fill, overflow, simultaneous-at-full, drain, underflow, both-at-empty.
            for (int i = 0; i < 16; i++)
                tbl[i] = '{1'b1, 1'b0, 8'(i), mk(i + 1, m && i < 2, 0, 0)};
            tbl[16] = '{1'b1, 1'b0, 8'h99, mk(16, 0, 1, 0)};
            tbl[17] = '{1'b1, 1'b1, 8'hEE, mk(15, 0, 1, 0)};
            for (int k = 0; k < 15; k++)
                tbl[18 + k] = '{1'b0, 1'b1, 8'h00, mk(14 - k, k == 14, 0, 0)};
            tbl[33] = '{1'b0, 1'b1, 8'h00, mk(0, 1, 0, 1)};
            tbl[34] = '{1'b1, 1'b1, 8'h77, mk(1, m, 0, 1)};
            for (int i = 0; i < 35; i++) begin
                step(tbl[i].w, tbl[i].r, tbl[i].d);
                chk($sformatf("row%0d", i), st(), tbl[i].exp);
            end
            flush();

            // Half-full streaming then random traffic; pointers wrap several times.
            do_reset();
            for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
            repeat (2) step(1'b0, 1'b0, 8'h00);
            for (int i = 0; i < 40; i++) begin
                step(1'b1, 1'b1, 8'($urandom));
                chk("stream_lvl", o.lvl, 8);
                chk("stream_vld", o.rvld, 1);
            end
            for (int i = 0; i < 40; i++) begin
                bit w, r;
                w = (mlvl < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
                r = (mlvl > 1)  ? 1'($urandom_range(0, 1)) : 1'b0;
                if (m && !o.rvld) r = 1'b0;
                step(w, r, 8'($urandom));
                chk("rand_lvl", o.lvl, mlvl);
            end
            flush();
        end

        // FWFT latency and gap-free burst.
        m = 1'b1;
        do_reset();
        step(1'b1, 1'b0, 8'hA5);
        chk("lat_n_lvl", o.lvl, 1);
        chk("lat_n_vld", o.rvld, 0);
        step(1'b0, 1'b0, 8'h00);
        chk("lat_n1_vld", o.rvld, 0);
        step(1'b0, 1'b0, 8'h00);
        chk("lat_n2_vld", o.rvld, 1);
        chk("lat_n2_data", o.data, 8'hA5);
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        repeat (2) step(1'b0, 1'b0, 8'h00);
        begin
            int nv = 0;
            for (int i = 0; i < 10; i++) begin
                if (o.rvld) nv++;
                step(1'b0, 1'b1, 8'h00);
            end
            chk("burst_valid_cycles", nv, 10);
        end
        chk("burst_empty", o.empty, 1);

        // Asynchronous reset with a pop pending, then a clean restart.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        repeat (3) step(1'b0, 1'b0, 8'h00);
        chk("pre_rst_lvl", o.lvl, 7);
        rd_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        rv = '0; rv.empty = 1'b1; rv.ae = 1'b1;
        chk("mid_rst_async", o, rv);
        do_reset();
        step(1'b1, 1'b0, 8'h3C);
        repeat (2) step(1'b0, 1'b0, 8'h00);
        chk("post_rst_vld", o.rvld, 1);
        chk("post_rst_data", o.data, 8'h3C);
        flush();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO built on an inferred dual-port RAM with registered read. It adds occupancy tracking, full/empty and programmable almost-full/almost-empty flags, overflow/underflow detection, and a selectable standard or first-word-fall-through (FWFT) read mode. It sits between same-clock producers and consumers in the pixel/data paths, where a bare RAM plus hand-rolled pointers is used today.

## Interface
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 10, RAM address width; DEPTH = 2**ADDR_WIDTH words, all usable.
- MODE, FIFO_STD, read mode (fifo_mode_e: FIFO_STD or FIFO_FWFT).
- AFULL_THRESH, DEPTH-4, almost_full asserts when level >= AFULL_THRESH.
- AEMPTY_THRESH, 4, almost_empty asserts when level <= AEMPTY_THRESH.
- clk  in  1  single clock; all signals synchronous to it.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AFULL_THRESH.
- overflow  out  1  one-cycle pulse: wr_en while full.
- rd_en  in  1  STD: read request; FWFT: pop/acknowledge of rd_data.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  STD: rd_data valid (1 cycle after accepted rd_en); FWFT: rd_data holds head word.
- empty  out  1  STD: level == 0; FWFT: !rd_valid.
- almost_empty  out  1  level <= AEMPTY_THRESH.
- underflow  out  1  one-cycle pulse: rd_en while empty (STD) or while !rd_valid (FWFT).
- level  out  ADDR_WIDTH+1  words held, 0..DEPTH, including any prefetched words.

## Operation
- Write accepted iff wr_en && !full; it stores to RAM[wr_ptr] and wr_ptr increments. Writes on full are dropped and pulse overflow. A read in the same cycle does not make room.
- STD read accepted iff rd_en && !empty. It reads RAM[rd_ptr], rd_ptr increments, and rd_data/rd_valid register on the next edge. When not reading, rd_data holds its last value.
- FWFT: a prefetch pointer reads ahead into a two-stage pipeline (RAM output register plus output register/skid), sustaining 1 pop/cycle. RAM slots free only on pop, so capacity is DEPTH in both modes. Prefetch reads only addresses written on an earlier edge, which avoids same-address read/write collisions.
- level is updated as level + wr_accept - rd_accept (pop in FWFT). Simultaneous accepted read and write leaves level unchanged.
- All flags are registered from next-state level, so they are exact on the same edge as the level update.
- Pointers are ADDR_WIDTH bits and wrap naturally modulo DEPTH. Full/empty come from level, never from pointer comparison.
- Reset (async assert, any time, including mid-burst) clears pointers, level and pipeline valids. Outputs at reset: full=0, almost_full=0, overflow=0, empty=1, almost_empty=1 (when AEMPTY_THRESH >= 0), underflow=0, rd_valid=0, rd_data=0, level=0. RAM contents are not reset; stale data must never appear with rd_valid=1.

## Timing
- STD: write accepted at edge N → empty=0, level=1 after N. rd_en accepted at edge M → rd_valid=1 with data after M+1.
- FWFT: write to an empty FIFO accepted at edge N → rd_valid=1 and empty=0 after N+2. level=1 already after N.
- FWFT pop at edge N with ≥2 further words queued → the next word is on rd_data after N, with no bubble.
- Back-to-back wr_en and rd_en at half-full: throughput 1 word/cycle each, and level is constant.
- overflow and underflow are high for exactly the cycle after the offending edge.

## Structure
- fifo_pkg: fifo_mode_e {FIFO_STD, FIFO_FWFT}, and a function computing the level width from ADDR_WIDTH.
- Sub-module fifo_mem: storage array with one write port and a registered read, no reset (maps to block RAM). sync_fifo instantiates it once. Pointers, level, flags and the FWFT prefetch stay in sync_fifo.

## Test plan
- Fill/drain (both modes, ADDR_WIDTH=4): 16 writes of 0..15 → full=1, level=16; 17th write → overflow pulse, data dropped; 16 reads → 0..15 in order, then empty=1; an extra rd_en → underflow pulse.
- Wrap-around: 40 interleaved writes/reads with level kept in 1..15 → output sequence equals input and pointers wrap twice.
- Simultaneous: at level=16, wr_en and rd_en together → read accepted, write dropped, level=15. At level=0 in STD, both together → write accepted, no read, level=1.
- FWFT latency: single write of 0xA5 into an empty FIFO → rd_valid rises exactly 2 edges later with rd_data=0xA5; continuous pops of a 10-word burst → 10 consecutive valid cycles.
- Thresholds: AFULL_THRESH=12, AEMPTY_THRESH=3 → almost_full rises on the edge level hits 12, almost_empty falls on the edge level hits 4.
- Reset mid-operation: assert rst_n=0 with level=7 and a FWFT pop pending → all outputs take reset values immediately (asynchronously). After release, a new write 0x3C → first rd_data=0x3C, with no stale words.
